adrv9009_hb_decim: RTL and testbench

- Parametrised half-band decimate-by-2 FIR for the ADRV9009 receive signal path.
- Generalised successor to the pass-through RHB2 stage: a real 11-tap symmetric half-band filter with input qualification, selectable bypass and output saturation.
- Sits between upstream receive filter stages and downstream decimators.
- One clock, streaming valid-qualified samples in; one output per two accepted inputs.

---
 rtl/adrv9009_hb_decim.sv | 145 ++++++++++++++
 tb/tb_adrv9009_hb_decim.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/adrv9009_hb_decim.sv
// Half-band decimate-by-2 FIR (11 taps, fixed coefficients) with bypass and output saturation.
// Define HB_DECIM_ROUND_EN to round half up before the shift; otherwise the shift truncates.
module adrv9009_hb_decim #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned COEF_W = 12,
    parameter int unsigned SHIFT  = 10
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              bypass_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_i,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_o
);

    localparam int unsigned ACC_W = DATA_W + COEF_W + 2;
    localparam int unsigned PRE_W = DATA_W + 1;

    localparam logic signed [COEF_W-1:0] C0 = COEF_W'(9);
    localparam logic signed [COEF_W-1:0] C2 = COEF_W'(-53);
    localparam logic signed [COEF_W-1:0] C4 = COEF_W'(300);

    localparam logic signed [ACC_W-1:0] SatMax = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SatMin = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

`ifdef HB_DECIM_ROUND_EN
    localparam logic signed [ACC_W-1:0] RoundK = ACC_W'(1) << (SHIFT - 1);
`else
    localparam logic signed [ACC_W-1:0] RoundK = '0;
`endif

    logic signed [DATA_W-1:0] x_q [11];
    logic signed [DATA_W-1:0] x_b [11];
    logic signed [DATA_W-1:0] x_d [11];
    logic                     phase_q, phase_d;
    logic                     byp_q;
    logic                     flush;
    logic                     accept;
    logic                     launch_q, launch_d;
    logic                     v1_q, v2_q;

    logic signed [PRE_W-1:0]  p0_q, p2_q, p4_q;
    logic signed [DATA_W-1:0] c_q;
    logic signed [ACC_W-1:0]  m0_q, m2_q, m4_q, mc_q;
    logic signed [ACC_W-1:0]  acc, shifted;
    logic signed [DATA_W-1:0] sat;

    logic [DATA_W-1:0]        out_q, out_d;
    logic                     out_valid_q, out_valid_d;

    // A change of the sampled bypass clears the window, phase and in-flight results.
    assign flush  = bypass_i ^ byp_q;
    assign accept = in_valid_i & ~bypass_i;

    always_comb begin
        for (int i = 0; i < 11; i++) begin
            x_b[i] = flush ? '0 : x_q[i];
            x_d[i] = x_b[i];
        end
        phase_d  = flush ? 1'b0 : phase_q;
        launch_d = 1'b0;
        if (accept) begin
            for (int i = 1; i < 11; i++) begin
                x_d[i] = x_b[i-1];
            end
            x_d[0]   = $signed(in_i);
            launch_d = phase_d;
            phase_d  = ~phase_d;
        end
    end

    always_comb begin
        acc     = m0_q + m2_q + m4_q + mc_q + RoundK;
        shifted = acc >>> SHIFT;
        if (shifted > SatMax) begin
            sat = SatMax[DATA_W-1:0];
        end else if (shifted < SatMin) begin
            sat = SatMin[DATA_W-1:0];
        end else begin
            sat = shifted[DATA_W-1:0];
        end
    end

    always_comb begin
        out_d       = out_q;
        out_valid_d = 1'b0;
        if (bypass_i) begin
            out_valid_d = in_valid_i;
            if (in_valid_i) begin
                out_d = in_i;
            end
        end else if (v2_q && !flush) begin
            out_valid_d = 1'b1;
            out_d       = sat;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 11; i++) begin
                x_q[i] <= '0;
            end
            phase_q     <= 1'b0;
            byp_q       <= 1'b0;
            launch_q    <= 1'b0;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            p0_q        <= '0;
            p2_q        <= '0;
            p4_q        <= '0;
            c_q         <= '0;
            m0_q        <= '0;
            m2_q        <= '0;
            m4_q        <= '0;
            mc_q        <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < 11; i++) begin
                x_q[i] <= x_d[i];
            end
            phase_q     <= phase_d;
            byp_q       <= bypass_i;
            launch_q    <= launch_d;
            v1_q        <= launch_q & ~flush;
            v2_q        <= v1_q & ~flush;
            // Datapath runs freely; only the valid chain decides what reaches out.
            p0_q        <= PRE_W'(x_q[0]) + PRE_W'(x_q[10]);
            p2_q        <= PRE_W'(x_q[2]) + PRE_W'(x_q[8]);
            p4_q        <= PRE_W'(x_q[4]) + PRE_W'(x_q[6]);
            c_q         <= x_q[5];
            m0_q        <= ACC_W'(p0_q) * ACC_W'(C0);
            m2_q        <= ACC_W'(p2_q) * ACC_W'(C2);
            m4_q        <= ACC_W'(p4_q) * ACC_W'(C4);
            mc_q        <= ACC_W'(c_q) <<< 9;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_o       = out_q;
    assign out_valid_o = out_valid_q;

endmodule

// File: tb/tb_adrv9009_hb_decim.sv
// Randomized and directed bench for adrv9009_hb_decim against a convolution-based reference model.
module tb_adrv9009_hb_decim;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          bypass = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_d = '0;
    logic          out_valid;
    logic [DW-1:0] out_w;

    always #5 clk = ~clk;

    adrv9009_hb_decim #(
        .DATA_W(16),
        .COEF_W(12),
        .SHIFT (10)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .bypass_i   (bypass),
        .in_valid_i (in_valid),
        .in_i       (in_d),
        .out_valid_o(out_valid),
        .out_o      (out_w)
    );

    typedef struct {
        int due;
        int val;
    } ev_t;

    int   n_total = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   hist[$];
    ev_t  pend[$];
    int   got[$];
    logic m_byp = 1'b0;
    int   last_out = 0;
    int   h[11] = '{9, 0, -53, 0, 300, 512, 300, 0, -53, 0, 9};
    int   imp1[7] = '{9, -53, 300, 300, -53, 9, 0};
    int   imp0[4] = '{0, 0, 512, 0};
    int   pat[11];

    task automatic check_eq(input string tag, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, act, exp);
        end
    endtask

    // y for the newest window: sum h[j] * x[n-j], shift by 10, saturate to 16 bits
    function automatic int ref_out();
        longint acc = 0;
        int     n = hist.size() - 1;
        for (int j = 0; j < 11; j++) begin
            if (n - j >= 0) acc += longint'(h[j]) * longint'(hist[n-j]);
        end
`ifdef HB_DECIM_ROUND_EN
        acc += 512;
`endif
        acc = acc >>> 10;
        if (acc > 32767) acc = 32767;
        if (acc < -32768) acc = -32768;
        return int'(acc);
    endfunction

    function automatic int got_at(input int i);
        return (i < got.size()) ? got[i] : -99999;
    endfunction

    task automatic step(input logic v, input int d, input logic b);
        logic exp_v;
        int   exp_o;
        in_valid = v;
        in_d     = d[DW-1:0];
        bypass   = b;
        @(posedge clk);
        cyc++;
        if (b != m_byp) begin
            hist.delete();
            pend.delete();
        end
        m_byp = b;
        exp_v = 1'b0;
        exp_o = last_out;
        if (b) begin
            if (v) begin
                exp_v = 1'b1;
                exp_o = int'($signed(d[DW-1:0]));
            end
        end else begin
            if (v) begin
                hist.push_back(int'($signed(d[DW-1:0])));
                if (hist.size() % 2 == 0) pend.push_back('{due: cyc + 3, val: ref_out()});
            end
            if (pend.size() > 0 && pend[0].due == cyc) begin
                exp_v = 1'b1;
                exp_o = pend[0].val;
                void'(pend.pop_front());
            end
        end
        #1;
        check_eq("out_valid", int'(out_valid), int'(exp_v));
        check_eq("out", int'($signed(out_w)), exp_o);
        if (out_valid) got.push_back(int'($signed(out_w)));
        last_out = exp_o;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_eq("rst_out", int'($signed(out_w)), 0);
        check_eq("rst_valid", int'(out_valid), 0);
        in_valid = 1'b0;
        bypass   = 1'b0;
        repeat (2) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        rst_n    = 1'b1;
        hist.delete();
        pend.delete();
        got.delete();
        m_byp    = 1'b0;
        last_out = 0;
    endtask

    task automatic sat_run(input int pos, input int neg, input int exp);
        do_reset();
        for (int j = 0; j < 11; j++) pat[j] = 0;
        pat[0] = pos; pat[4] = pos; pat[5] = pos; pat[6] = pos; pat[10] = pos;
        pat[2] = neg; pat[8] = neg;
        step(1'b1, 0, 1'b0);
        for (int k = 1; k < 12; k++) step(1'b1, pat[11-k], 1'b0);
        repeat (4) step(1'b0, 0, 1'b0);
        check_eq("sat_last", got_at(5), exp);
    endtask

    initial begin
        logic    b;
        logic [15:0] r;
        int      d;
        #2;
        do_reset();

        // impulse on the phase-1 sample
        step(1'b1, 0, 1'b0);
        step(1'b1, 1024, 1'b0);
        repeat (16) step(1'b1, 0, 1'b0);
        for (int i = 0; i < 7; i++) check_eq("imp_ph1", got_at(i), imp1[i]);

        // impulse on the phase-0 sample: center tap only
        do_reset();
        step(1'b1, 1024, 1'b0);
        repeat (16) step(1'b1, 0, 1'b0);
        for (int i = 0; i < 4; i++) check_eq("imp_ph0", got_at(i), imp0[i]);

        // DC gain, continuous then gapped (junk data on idle cycles)
        do_reset();
        repeat (24) step(1'b1, 1000, 1'b0);
        for (int i = 5; i < 10; i++) check_eq("dc_cont", got_at(i), 1000);
        do_reset();
        for (int i = 0; i < 72; i++) step(i % 3 == 0, (i % 3 == 0) ? 1000 : int'($urandom), 1'b0);
        for (int i = 5; i < 10; i++) check_eq("dc_gap", got_at(i), 1000);

        sat_run(32767, -32768, 32767);
        sat_run(-32768, 32767, -32768);

        // rounding of +/-1 center-tap impulse
        do_reset();
        step(1'b1, 1, 1'b0);
        repeat (8) step(1'b1, 0, 1'b0);
`ifdef HB_DECIM_ROUND_EN
        check_eq("round_pos", got_at(2), 1);
`else
        check_eq("round_pos", got_at(2), 0);
`endif
        do_reset();
        step(1'b1, -1, 1'b0);
        repeat (8) step(1'b1, 0, 1'b0);
`ifdef HB_DECIM_ROUND_EN
        check_eq("round_neg", got_at(2), 0);
`else
        check_eq("round_neg", got_at(2), -1);
`endif

        // ramp through bypass on/off
        do_reset();
        for (int i = 1; i <= 12; i++) step(1'b1, i, 1'b0);
        for (int i = 13; i <= 22; i++) step(1'b1, i, 1'b1);
        for (int i = 23; i <= 36; i++) step(1'b1, i, 1'b0);

        // asynchronous reset mid-stream
        do_reset();
        for (int i = 1; i <= 9; i++) step(1'b1, i * 100, 1'b0);
        do_reset();
        for (int i = 1; i <= 20; i++) step(1'b1, i * 37, 1'b0);

        // random traffic with occasional bypass toggles and full-scale values
        do_reset();
        b = 1'b0;
        for (int i = 0; i < 800; i++) begin
            r = 16'($urandom);
            d = int'($signed(r));
            if ($urandom_range(0, 3) == 0) d = ($urandom_range(0, 1) == 1) ? 32767 : -32768;
            if ($urandom_range(0, 39) == 0) b = ~b;
            step($urandom_range(0, 3) != 0, d, b);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
